// File: rtl/mac_array_pipe_pkg.sv
// mac_array_pipe_pkg: shared types and helpers for the pipelined MAC array.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: default accumulator width, lane slice helper, overflow test and saturating narrow.
package mac_array_pipe_pkg;

  localparam int N_DEF     = 8;
  localparam int Q_DEF     = 4;
  localparam int LANES_DEF = 4;

  // Control that travels alongside the operands through the pipeline.
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } beat_tag_t;

  // Full product width plus 4 guard bits: 16 beats of max product cannot wrap.
  function automatic int acc_w_default(input int n);
    return 2 * n + 4;
  endfunction

  // Low bit index of lane 'lane' inside a packed LANES*n bus.
  function automatic int lane_lo(input int lane, input int n);
    return lane * n;
  endfunction

  // True when r does not fit an n-bit signed value.
  function automatic logic ovf_check(input logic signed [63:0] r, input int n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    return (r > hi) || (r < lo);
  endfunction

  // Clamp r into the n-bit signed range; caller keeps the low n bits.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] r, input int n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (r > hi) return hi;
    else if (r < lo) return lo;
    else return r;
  endfunction

endpackage

// File: rtl/mac_array_pipe_lane.sv
// mac_array_pipe_lane: one MAC lane -- S1 product register, S2 accumulator, result narrowing.
// Latency: product 1 cycle after s1_load, accumulator 1 cycle after s2_step; res/ovf combinational from acc.
// Backpressure: none internally; the parent gates s1_load/s2_step with its advance enable.
// Ports: clk, rst_n, clr, s1_load, c_load, s2_step, seed, a, b, c -> res, ovf.
// Build option: SATURATE_EN selects clamping of overflowing results instead of wrapping.
module mac_array_pipe_lane
  import mac_array_pipe_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int Q     = Q_DEF,
  parameter int ACC_W = acc_w_default(N_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                s1_load,
  input  logic                c_load,
  input  logic                s2_step,
  input  logic                seed,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic signed [N-1:0] c,
  output logic        [N-1:0] res,
  output logic                ovf
);

  logic signed [2*N-1:0]   prod_q;
  logic signed [N-1:0]     c_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] seed_x;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] r;
  logic signed [2*N-1:0]   prod_w;

  assign prod_w = a * b;

  // S1: product and bias; bias only captured on first beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      c_q    <= '0;
    end else if (clr) begin
      prod_q <= '0;
      c_q    <= '0;
    end else begin
      if (s1_load) prod_q <= prod_w;
      if (c_load)  c_q    <= c;
    end
  end

  // Bias is in Q frac bits, product in 2Q: shift bias up to align.
  assign prod_x  = ACC_W'(prod_q);
  assign seed_x  = ACC_W'(c_q) <<< Q;
  assign acc_nxt = seed ? (seed_x + prod_x) : (acc + prod_x);

  // S2: accumulator; wraps modulo 2^ACC_W by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (s2_step) begin
      acc <= acc_nxt;
    end
  end

  // Drop Q frac bits with an arithmetic shift (rounds toward -inf).
  assign r   = acc >>> Q;
  assign ovf = ovf_check(64'(r), N);

`ifdef SATURATE_EN
  assign res = N'(sat_narrow(64'(r), N));
`else
  assign res = r[N-1:0];
`endif

endmodule

// File: rtl/mac_array_pipe.sv
// mac_array_pipe: LANES-wide signed Q-format multiply-accumulate over first/last framed vectors.
// Latency: out_valid rises 2 cycles after the last beat is accepted; sustains 1 beat/cycle.
// Backpressure: out_valid & ~out_ready freezes S1, S2 and the output register; in_ready = ~stall.
// Ports: clk, rst_n, clr, in_valid/in_ready/in_first/in_last/in_a/in_b/in_c, out_valid/out_ready/out_p/out_ovf.
// Build option: define SATURATE_EN to clamp overflowing lanes; default build wraps to N bits.
module mac_array_pipe
  import mac_array_pipe_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int Q     = Q_DEF,
  parameter int LANES = LANES_DEF,
  parameter int ACC_W = acc_w_default(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_first,
  input  logic               in_last,
  input  logic [LANES*N-1:0] in_a,
  input  logic [LANES*N-1:0] in_b,
  input  logic [LANES*N-1:0] in_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] out_p,
  output logic [LANES-1:0]   out_ovf
);

  logic               stall;
  logic               adv;
  beat_tag_t          s1_tag;
  logic               s2_vld;
  logic               s2_last;
  logic               s2_done;
  logic [LANES*N-1:0] lane_res;
  logic [LANES-1:0]   lane_ovf;

  // The whole pipe moves as one; a held result blocks everything behind it.
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;
  assign s2_done  = s2_vld & s2_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_tag  <= '0;
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
    end else if (clr) begin
      s1_tag  <= '0;
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
    end else if (adv) begin
      s1_tag.vld   <= in_valid;
      s1_tag.first <= in_first;
      s1_tag.last  <= in_last;
      s2_vld       <= s1_tag.vld;
      s2_last      <= s1_tag.last;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_array_pipe_lane #(
      .N     (N),
      .Q     (Q),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .s1_load (adv & in_valid),
      .c_load  (adv & in_valid & in_first),
      .s2_step (adv & s1_tag.vld),
      .seed    (s1_tag.first),
      .a       (in_a[lane_lo(i, N) +: N]),
      .b       (in_b[lane_lo(i, N) +: N]),
      .c       (in_c[lane_lo(i, N) +: N]),
      .res     (lane_res[lane_lo(i, N) +: N]),
      .ovf     (lane_ovf[i])
    );
  end

  // When not stalled the previous result is either absent or being taken,
  // so a finishing vector can load straight in with out_valid staying high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_ovf   <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_ovf   <= '0;
    end else if (adv) begin
      out_valid <= s2_done;
      if (s2_done) begin
        out_p   <= lane_res;
        out_ovf <= lane_ovf;
      end
    end
  end

endmodule
